// File: rtl/mips_mem_dump_if.sv
// Bus bundle for mips_mem_dump: control, synchronous memory read port and output stream.
// master = the dump engine, slave = the host/memory side.
interface mips_mem_dump_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 11
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  count;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    input  start, abort, base_addr, count, mem_rd_data, out_ready,
    output busy, done, mem_rd_en, mem_addr, out_data, out_valid, out_last
  );

  modport slave (
    output start, abort, base_addr, count, mem_rd_data, out_ready,
    input  busy, done, mem_rd_en, mem_addr, out_data, out_valid, out_last
  );
endinterface

// File: rtl/mips_mem_dump.sv
// Post-run memory readback: reads a wrapping window of word memory and streams it out.
// Optional trailing XOR checksum beat when MEM_DUMP_CSUM_EN is defined.
module mips_mem_dump #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 11
) (
  input  logic            clk1,
  input  logic            rst_n,
  mips_mem_dump_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_CAPT, S_HOLD, S_FIN} state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_rem;
  logic [DATA_W-1:0] r_data;
  logic              w_hs;
  logic              w_last_mem;
  logic              w_tail;

`ifdef MEM_DUMP_CSUM_EN
  logic [DATA_W-1:0] r_csum;
  logic              r_csb;   // currently presenting the checksum beat
  assign w_tail = r_csb;
`else
  assign w_tail = w_last_mem;
`endif

  assign w_hs       = (r_state == S_HOLD) && bus.out_ready;
  assign w_last_mem = (r_rem == CNT_W'(1));

  always_ff @(posedge clk1) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    bus.busy      = (r_state != S_IDLE);
    bus.done      = (r_state == S_FIN);
    bus.mem_rd_en = (r_state == S_REQ);
    bus.mem_addr  = (r_state == S_REQ) ? r_addr : '0;
    bus.out_valid = (r_state == S_HOLD);
    bus.out_data  = (r_state == S_HOLD) ? r_data : '0;
    bus.out_last  = (r_state == S_HOLD) && w_tail;
    case (r_state)
      S_IDLE: if (bus.start) w_next = (bus.count == '0) ? S_FIN : S_REQ;
      S_REQ:  w_next = S_CAPT;
      S_CAPT: w_next = S_HOLD;
      S_HOLD: if (w_hs) begin
`ifdef MEM_DUMP_CSUM_EN
        if (r_csb)           w_next = S_FIN;
        else if (w_last_mem) w_next = S_HOLD;
        else                 w_next = S_REQ;
`else
        w_next = w_last_mem ? S_FIN : S_REQ;
`endif
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // abort wins over any same-cycle handshake
    if (bus.abort && r_state != S_IDLE) w_next = S_IDLE;
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_rem  <= '0;
      r_data <= '0;
`ifdef MEM_DUMP_CSUM_EN
      r_csum <= '0;
      r_csb  <= 1'b0;
`endif
    end else begin
      if (r_state == S_IDLE && bus.start) begin
        r_addr <= bus.base_addr;
        r_rem  <= bus.count;
`ifdef MEM_DUMP_CSUM_EN
        r_csum <= '0;
        r_csb  <= 1'b0;
`endif
      end
      if (r_state == S_CAPT) begin
        r_data <= bus.mem_rd_data;
`ifdef MEM_DUMP_CSUM_EN
        r_csum <= r_csum ^ bus.mem_rd_data;
`endif
      end
      if (w_hs && !bus.abort) begin
`ifdef MEM_DUMP_CSUM_EN
        if (!r_csb) begin
          r_addr <= r_addr + ADDR_W'(1);
          r_rem  <= r_rem - CNT_W'(1);
          // final memory word consumed: swap the checksum into the hold register
          if (w_last_mem) begin
            r_data <= r_csum;
            r_csb  <= 1'b1;
          end
        end
`else
        r_addr <= r_addr + ADDR_W'(1);
        r_rem  <= r_rem - CNT_W'(1);
`endif
      end
    end
  end
endmodule

// File: tb/tb_mips_mem_dump.sv
// Self-checking bench for mips_mem_dump: memory model, queue scoreboard, directed + random dumps.
module tb_mips_mem_dump;
  logic clk1 = 1'b0;
  logic rst_n;
  always #5 clk1 = ~clk1;

  mips_mem_dump_if #(.ADDR_W(10), .DATA_W(32), .CNT_W(11)) bus();
  mips_mem_dump #(.ADDR_W(10), .DATA_W(32), .CNT_W(11)) dut (
    .clk1(clk1), .rst_n(rst_n), .bus(bus.master)
  );

  logic [31:0] mem [1024];
  always @(posedge clk1) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];

  int vecs = 0, fails = 0, cyc = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
  bit dump_open = 0;
  int          exp_rd[$];
  logic [31:0] exp_d[$];
  bit          exp_l[$];
  int          seen_a[$];
  logic [31:0] seen_d[$];
  bit          seen_l[$];
  logic        prev_v = 0, prev_r = 0, prev_l = 0, prev_rst = 0, prev_ab = 0;
  logic [31:0] prev_d = 0;

  always @(posedge clk1) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk1) begin
    if (prev_v && !prev_r && prev_rst && !prev_ab) begin
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_data", bus.out_data, prev_d);
      chk("stall_last", bus.out_last, prev_l);
    end
    if (bus.mem_rd_en) begin
      seen_a.push_back(int'(bus.mem_addr));
      chk("rd_expected", exp_rd.size() != 0, 1);
      if (exp_rd.size() != 0) chk("rd_addr", bus.mem_addr, exp_rd.pop_front());
    end
    if (bus.out_valid && bus.out_ready) begin
      seen_d.push_back(bus.out_data);
      seen_l.push_back(bus.out_last);
      chk("beat_expected", exp_d.size() != 0, 1);
      if (exp_d.size() != 0) begin
        chk("beat_data", bus.out_data, exp_d.pop_front());
        chk("beat_last", bus.out_last, exp_l.pop_front());
      end
    end
    if (bus.done) begin
      chk("done_expected", dump_open, 1);
      chk("done_pending", exp_d.size() + exp_rd.size(), 0);
      dump_open = 0;
      done_cnt++;
      done_cyc = cyc;
    end
    prev_v = bus.out_valid; prev_r = bus.out_ready; prev_d = bus.out_data;
    prev_l = bus.out_last;  prev_rst = rst_n;       prev_ab = bus.abort;
  end

  // reference: the words a dump must read and emit, straight from the window definition
  task automatic expect_dump(input int base, input int cnt);
    logic [31:0] x;
    x = 0;
    exp_rd.delete(); exp_d.delete(); exp_l.delete();
    seen_a.delete(); seen_d.delete(); seen_l.delete();
    for (int i = 0; i < cnt; i++) begin
      int a;
      a = (base + i) % 1024;
      exp_rd.push_back(a);
      exp_d.push_back(mem[a]);
      x = x ^ mem[a];
`ifdef MEM_DUMP_CSUM_EN
      exp_l.push_back(1'b0);
`else
      exp_l.push_back(i == cnt - 1);
`endif
    end
`ifdef MEM_DUMP_CSUM_EN
    if (cnt != 0) begin exp_d.push_back(x); exp_l.push_back(1'b1); end
`endif
    dump_open = 1;
  endtask

  task automatic drop_expect();
    exp_rd.delete(); exp_d.delete(); exp_l.delete();
    dump_open = 0;
  endtask

  // mode 0: random ready, 1: ready held high, 2: five stall cycles per beat
  task automatic run_dump(input int base, input int cnt, input int mode, input bit inj);
    int n0, k, st, lat;
    n0 = done_cnt; k = 0; st = 0;
    expect_dump(base, cnt);
    bus.start = 1; bus.base_addr = 10'(base); bus.count = 11'(cnt);
    bus.out_ready = (mode == 1);
    start_cyc = cyc;
    @(posedge clk1); #1;
    bus.start = 0; bus.base_addr = 10'($urandom); bus.count = 11'($urandom);
    @(negedge clk1);
    chk("rd_en_t1", bus.mem_rd_en, cnt != 0);
    chk("busy_t1", bus.busy, 1);
    while (done_cnt == n0 && k < 3000) begin
      @(posedge clk1); #1;
      k++;
      case (mode)
        0: bus.out_ready = 1'($urandom_range(0, 1));
        1: bus.out_ready = 1;
        default: begin
          if (bus.out_valid) begin
            if (st < 5) begin bus.out_ready = 0; st++; end
            else begin bus.out_ready = 1; st = 0; end
          end else bus.out_ready = 0;
        end
      endcase
      if (inj && k == 4) begin
        bus.start = 1; bus.base_addr = 0; bus.count = 3;
      end else bus.start = 0;
    end
    bus.start = 0;
    if (done_cnt == n0) begin
      chk("dump_timeout", done_cnt, n0 + 1);
      drop_expect();
    end else if (mode == 1) begin
      lat = 1 + 3 * cnt;
`ifdef MEM_DUMP_CSUM_EN
      if (cnt != 0) lat = lat + 1;
`endif
      chk("done_latency", done_cyc - start_cyc, lat);
    end
    bus.out_ready = 0;
    @(negedge clk1);
    chk("busy_after", bus.busy, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_rd_en"}, bus.mem_rd_en, 0);
    chk({tag, "_addr"}, bus.mem_addr, 0);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_last"}, bus.out_last, 0);
    chk({tag, "_data"}, bus.out_data, 0);
  endtask

  initial begin
    int k, n0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[120] = 85; mem[121] = 130;
    rst_n = 0; bus.start = 0; bus.abort = 0; bus.base_addr = 0; bus.count = 0;
    bus.out_ready = 0; bus.mem_rd_data = 0;
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    chk_zero("reset");
    @(posedge clk1); #1; rst_n = 1;

    // basic dump with literal pins
    run_dump(120, 2, 1, 0);
    chk("basic_nrd", seen_a.size(), 2);
    chk("basic_a0", seen_a[0], 120);
    chk("basic_a1", seen_a[1], 121);
    chk("basic_d0", seen_d[0], 85);
    chk("basic_d1", seen_d[1], 130);
    chk("basic_l0", seen_l[0], 0);
`ifdef MEM_DUMP_CSUM_EN
    chk("basic_l1", seen_l[1], 0);
    chk("csum_d2", seen_d[2], 215);
    chk("csum_l2", seen_l[2], 1);
`else
    chk("basic_l1", seen_l[1], 1);
    chk("basic_nbeat", seen_d.size(), 2);
`endif

    // backpressure
    run_dump(120, 2, 2, 0);
    chk("bp_nrd", seen_a.size(), 2);
    chk("bp_d0", seen_d[0], 85);
    chk("bp_d1", seen_d[1], 130);

    // wrap
    run_dump(1022, 4, 0, 0);
    chk("wrap_a0", seen_a[0], 1022);
    chk("wrap_a1", seen_a[1], 1023);
    chk("wrap_a2", seen_a[2], 0);
    chk("wrap_a3", seen_a[3], 1);

    // zero count
    run_dump(77, 0, 1, 0);
    chk("zero_nrd", seen_a.size(), 0);
    chk("zero_nbeat", seen_d.size(), 0);

    // ignored start mid-dump
    run_dump(120, 2, 1, 1);
    chk("ign_a0", seen_a[0], 120);
    chk("ign_a1", seen_a[1], 121);

    // abort during second HOLD of a 4-word dump
    n0 = done_cnt;
    expect_dump(200, 4);
    bus.start = 1; bus.base_addr = 200; bus.count = 4;
    @(posedge clk1); #1;
    bus.start = 0; bus.out_ready = 1; k = 0;
    while (!(seen_d.size() == 1 && bus.out_valid) && k < 100) begin
      @(posedge clk1); #1; k++;
      if (seen_d.size() >= 1) bus.out_ready = 0;
    end
    chk("abort_reach_hold2", seen_d.size(), 1);
    bus.out_ready = 0; bus.abort = 1;
    @(posedge clk1); #1;
    bus.abort = 0;
    drop_expect();
    @(negedge clk1);
    chk_zero("abort");
    repeat (3) @(negedge clk1);
    chk("abort_no_done", done_cnt, n0);
    run_dump(120, 2, 1, 0);
    chk("post_abort_d1", seen_d[1], 130);

    // reset mid-dump
    expect_dump(300, 4);
    bus.start = 1; bus.base_addr = 300; bus.count = 4;
    @(posedge clk1); #1;
    bus.start = 0;
    repeat (5) begin @(posedge clk1); #1; bus.out_ready = 1'($urandom_range(0, 1)); end
    n0 = done_cnt;
    rst_n = 0;
    @(posedge clk1); #1;
    drop_expect();
    @(negedge clk1);
    chk_zero("midrst");
    chk("midrst_no_done", done_cnt, n0);
    @(posedge clk1); #1;
    rst_n = 1; bus.out_ready = 0;

    // random dumps
    for (int it = 0; it < 25; it++)
      run_dump(int'($urandom_range(0, 1023)), int'($urandom_range(0, 8)),
               int'($urandom_range(0, 2)), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
